// File: rtl/pipeline_hazard_tracker.sv
// pipeline_hazard_tracker
//
// Sits beside the ID stage. It keeps a short shift register of destination
// tags for every downstream stage (stage 1 = EX, 2 = MEM, 3 = WB, ...). From
// those tags it computes operand-forwarding selects and load-use stalls for
// the instruction currently in ID. It also counts the cycles in which stall
// was high.
//
// There is no valid/ready handshake in this block. The ID inputs are sampled
// on every rising clk edge. The stage tags advance unconditionally on every
// edge, and a stall is expressed only by loading a bubble into stage 1.
//
// Ports
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs1/id_rs1_used  source 1 address / instruction reads it
//   id_rs2/id_rs2_used  source 2 address / instruction reads it
//   id_rd/id_reg_wr     destination address / instruction writes it
//   id_mem_rd           the ID instruction is a load
//   kill                squash the ID instruction (taken branch/jump)
//   stall               hold PC and IF/ID, inject a bubble into stage 1
//   fwd_a/fwd_b         0 = register file, k = forward from stage k
//   stage_valid         bit k-1 : stage k holds a valid instruction
//   stage_reg_wr        bit k-1 : stage k writes its rd
//   stage_rd            slice k-1 : rd of stage k
//   stall_count         saturating count of stalled cycles
module pipeline_hazard_tracker #(
    parameter int REG_AW   = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs1,
    input  logic                    id_rs1_used,
    input  logic [REG_AW-1:0]       id_rs2,
    input  logic                    id_rs2_used,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_reg_wr,
    input  logic                    id_mem_rd,
    input  logic                    kill,
    output logic                    stall,
    output logic [SEL_W-1:0]        fwd_a,
    output logic [SEL_W-1:0]        fwd_b,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH-1:0]        stage_reg_wr,
    output logic [DEPTH*REG_AW-1:0] stage_rd,
    output logic [CNT_W-1:0]        stall_count
);

    // Index i holds stage i+1.
    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  wr_q;
    logic [DEPTH-1:0]  ld_q;
    logic [REG_AW-1:0] rd_q [DEPTH];

    logic haz_a;
    logic haz_b;
    logic zero_a;
    logic zero_b;

    // Register 0 never matches when it is hardwired.
    assign zero_a = (ZERO_REG != 0) && (id_rs1 == '0);
    assign zero_b = (ZERO_REG != 0) && (id_rs2 == '0);

    // The loop walks from the oldest stage down to the youngest. The last
    // match found is therefore the youngest producer, which must win. The
    // hazard flag follows that same youngest match. An older ALU result
    // behind a younger load cannot hide the load.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (id_rs1_used && !zero_a && v_q[i] && wr_q[i] && (rd_q[i] == id_rs1)) begin
                fwd_a = SEL_W'(i + 1);
                haz_a = (i < LOAD_LAT) && ld_q[i];
            end
            if (id_rs2_used && !zero_b && v_q[i] && wr_q[i] && (rd_q[i] == id_rs2)) begin
                fwd_b = SEL_W'(i + 1);
                haz_b = (i < LOAD_LAT) && ld_q[i];
            end
        end
    end

    // kill wins: a squashed instruction never waits for its operands.
    assign stall = id_valid && !kill && (haz_a || haz_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            stall_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                v_q[i]  <= v_q[i-1];
                wr_q[i] <= wr_q[i-1];
                ld_q[i] <= ld_q[i-1];
                rd_q[i] <= rd_q[i-1];
            end
            if (stall || kill || !id_valid) begin
                v_q[0]  <= 1'b0;
                wr_q[0] <= 1'b0;
                ld_q[0] <= 1'b0;
                rd_q[0] <= '0;
            end else begin
                v_q[0]  <= 1'b1;
                wr_q[0] <= id_reg_wr;
                ld_q[0] <= id_mem_rd;
                rd_q[0] <= id_rd;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    assign stage_valid  = v_q;
    assign stage_reg_wr = wr_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd_pack
        assign stage_rd[g*REG_AW +: REG_AW] = rd_q[g];
    end

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
module tb_pipeline_hazard_tracker;

  localparam int REG_AW = 3;
  localparam int DEPTH  = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd, kill;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;

  logic                    stall, z0_stall;
  logic [SEL_W-1:0]        fwd_a, fwd_b, z0_fwd_a, z0_fwd_b;
  logic [DEPTH-1:0]        stage_valid, stage_reg_wr, z0_stage_valid, z0_stage_reg_wr;
  logic [DEPTH*REG_AW-1:0] stage_rd, z0_stage_rd;
  logic [CNT_W-1:0]        stall_count, z0_stall_count;

  int errors = 0;
  int checks = 0;

  // Main instance: register 0 hardwired.
  pipeline_hazard_tracker #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(1), .ZERO_REG(1), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .kill(kill),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_valid(stage_valid), .stage_reg_wr(stage_reg_wr), .stage_rd(stage_rd),
    .stall_count(stall_count)
  );

  // Second instance: register 0 is an ordinary register.
  pipeline_hazard_tracker #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(1), .ZERO_REG(0), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut_z0 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .kill(kill),
    .stall(z0_stall), .fwd_a(z0_fwd_a), .fwd_b(z0_fwd_b),
    .stage_valid(z0_stage_valid), .stage_reg_wr(z0_stage_reg_wr), .stage_rd(z0_stage_rd),
    .stall_count(z0_stall_count)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge. Outputs are checked 1
  // more unit later, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
    id_rd = '0; id_reg_wr = 1'b0; id_mem_rd = 1'b0; kill = 1'b0;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd, input logic wr, input logic ld,
                       input logic [REG_AW-1:0] rs1, input logic u1,
                       input logic [REG_AW-1:0] rs2, input logic u2);
    id_valid = 1'b1; id_rd = rd; id_reg_wr = wr; id_mem_rd = ld;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2; kill = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive_idle();
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    issue(3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    step();
    step();
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL reset_stage_valid: got %b expected %b", stage_valid, 3'b000); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", fwd_a); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    reset = 1'b0;
    drive_idle();
    step();
  endtask

  task automatic test_alu_chain();
    pulse_reset();
    issue(3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (stage_valid !== 3'b001) begin errors++; $display("FAIL chain_stage_valid: got %b expected 001", stage_valid); end
    checks++; if (stage_reg_wr !== 3'b001) begin errors++; $display("FAIL chain_stage_reg_wr: got %b expected 001", stage_reg_wr); end
    issue(3'd1, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL chain_fwd_a_c1: got %0d expected 1", fwd_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL chain_stall_c1: got %b expected 0", stall); end
    step();
    checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL chain_fwd_a_c2: got %0d expected 2", fwd_a); end
    step();
    checks++; if (fwd_a !== 2'd3) begin errors++; $display("FAIL chain_fwd_a_c3: got %0d expected 3", fwd_a); end
    step();
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL chain_fwd_a_c4: got %0d expected 0", fwd_a); end
    drive_idle();
    step();
  endtask

  task automatic test_shift();
    pulse_reset();
    issue(3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (stage_rd !== 9'b001_010_011) begin errors++; $display("FAIL shift_stage_rd: got %b expected %b", stage_rd, 9'b001_010_011); end
    checks++; if (stage_reg_wr !== 3'b101) begin errors++; $display("FAIL shift_stage_reg_wr: got %b expected 101", stage_reg_wr); end
    drive_idle();
    step();
    checks++; if (stage_valid !== 3'b110) begin errors++; $display("FAIL shift_drain_valid: got %b expected 110", stage_valid); end
  endtask

  task automatic test_load_use();
    pulse_reset();
    issue(3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c1: got %b expected 1", stall); end
    checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL lu_fwd_b_c1: got %0d expected 1", fwd_b); end
    step();
    checks++; if (stage_valid !== 3'b010) begin errors++; $display("FAIL lu_bubble: got %b expected 010", stage_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_c2: got %b expected 0", stall); end
    checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd_b_c2: got %0d expected 2", fwd_b); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_stall_count: got %0d expected 1", stall_count); end
    drive_idle();
    step();
  endtask

  task automatic test_priority();
    pulse_reset();
    issue(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1);
    settle();
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL prio_fwd_a: got %0d expected 1", fwd_a); end
    checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL prio_fwd_b_same_src: got %0d expected 1", fwd_b); end
    // Older ALU producer in stage 2 behind a younger load in stage 1.
    pulse_reset();
    issue(3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio_load_shadow_stall: got %b expected 1", stall); end
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL prio_load_shadow_fwd_a: got %0d expected 1", fwd_a); end
    drive_idle();
    step();
  endtask

  task automatic test_zero_reg();
    pulse_reset();
    issue(3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL zero_hw_fwd_a: got %0d expected 0", fwd_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_hw_stall: got %b expected 0", stall); end
    checks++; if (z0_fwd_a !== 2'd1) begin errors++; $display("FAIL zero_plain_fwd_a: got %0d expected 1", z0_fwd_a); end
    // A load to r0 stalls only where r0 is an ordinary register.
    pulse_reset();
    issue(3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_hw_load_stall: got %b expected 0", stall); end
    checks++; if (z0_stall !== 1'b1) begin errors++; $display("FAIL zero_plain_load_stall: got %b expected 1", z0_stall); end
    drive_idle();
    step();
  endtask

  task automatic test_kill();
    pulse_reset();
    issue(3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    kill = 1'b1;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall: got %b expected 0", stall); end
    step();
    checks++; if (stage_valid !== 3'b010) begin errors++; $display("FAIL kill_bubble: got %b expected 010", stage_valid); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL kill_stall_count: got %0d expected 0", stall_count); end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    issue(3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    issue(3'd1, 1'b0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall_before: got %b expected 1", stall); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall_after: got %b expected 0", stall); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rms_stall_count: got %0d expected 0", stall_count); end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back_saturation();
    pulse_reset();
    for (int n = 1; n <= 18; n++) begin
      issue(3'd7, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      issue(3'd1, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0);
      step();
      step();
      if (n == 3) begin
        checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL sat_count_3: got %0d expected 3", stall_count); end
      end
      if (n == 15) begin
        checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_count_15: got %0d expected 15", stall_count); end
      end
    end
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_count_hold: got %0d expected 15", stall_count); end
    drive_idle();
    step();
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_alu_chain();
    test_shift();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_kill();
    test_reset_mid_stall();
    test_back_to_back_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
